// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with runtime seed load and all-zero lock-up recovery.
// Define LFSR_PERIOD_EN to build the period monitor that drives wrap and period.
module lfsr_gen #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0000_00B8,
    parameter logic [31:0] SEED  = 32'd1,
    parameter int unsigned MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] value,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
    // A zero seed would park the register in the lock-up state, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_M = (SEED[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAP_M)};
    endfunction

    function automatic logic [WIDTH-1:0] gal_step(input logic [WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ TAP_M) : (v >> 1);
    endfunction

    logic [WIDTH-1:0] r_value;
    logic             r_lockup;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load_zero;
    logic             w_recover;
    logic             w_advance;

    assign w_step      = (MODE == 0) ? fib_step(r_value) : gal_step(r_value);
    assign w_load_zero = load && (seed_in == '0);
    assign w_load_val  = w_load_zero ? SEED_M : seed_in;
    assign w_recover   = !load && enable && (r_value == '0);
    assign w_advance   = !load && enable && (r_value != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value  <= SEED_M;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_load_zero || w_recover;
            if (load) begin
                r_value <= w_load_val;
            end else if (w_recover) begin
                r_value <= SEED_M;
            end else if (w_advance) begin
                r_value <= w_step;
            end
        end
    end

    assign value  = r_value;
    assign lockup = r_lockup;

`ifdef LFSR_PERIOD_EN
    // Saturating increment keeps a counter that never meets its start value from rolling over.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c);
        return (c == '1) ? c : c + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] r_period;
    logic             w_hit;

    assign w_hit = w_advance && (w_step == r_start);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start  <= SEED_M;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_period <= '0;
        end else begin
            r_wrap <= w_hit;
            if (load) begin
                r_start <= w_load_val;
                r_count <= '0;
            end else if (w_recover) begin
                r_start <= SEED_M;
                r_count <= '0;
            end else if (w_hit) begin
                r_period <= sat_inc(r_count);
                r_count  <= '0;
            end else if (w_advance) begin
                r_count <= sat_inc(r_count);
            end
        end
    end

    assign wrap   = r_wrap;
    assign period = r_period;
`else
    assign wrap   = 1'b0;
    assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: three instances (Fibonacci, Galois, zero-tap lock-up case)
// share one stimulus stream and are checked against a cycle-level sequence model.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] seed_in;

    logic [7:0] v0, v1, v2;
    logic       l0, l1, l2;
    logic       w0, w1, w2;
    logic [7:0] p0, p1, p2;

    int checks   = 0;
    int failures = 0;

    int q[$];

    int mtaps[3] = '{'hB8, 'hB8, 0};
    int mmode[3] = '{0, 1, 0};
    int mv[3];
    int mstart[3];
    int mcnt[3];
    int mper[3];

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(8), .TAPS(32'h0000_00B8), .SEED(32'd1), .MODE(0)) u_fib (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .value(v0), .lockup(l0), .wrap(w0), .period(p0));

    lfsr_gen #(.WIDTH(8), .TAPS(32'h0000_00B8), .SEED(32'd1), .MODE(1)) u_gal (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .value(v1), .lockup(l1), .wrap(w1), .period(p1));

    lfsr_gen #(.WIDTH(8), .TAPS(32'h0000_0000), .SEED(32'd0), .MODE(0)) u_zero (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .value(v2), .lockup(l2), .wrap(w2), .period(p2));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic sample(input int k, output int v, output int l, output int w, output int p);
        case (k)
            0: begin v = int'(v0); l = int'(l0); w = int'(w0); p = int'(p0); end
            1: begin v = int'(v1); l = int'(l1); w = int'(w1); p = int'(p1); end
            default: begin v = int'(v2); l = int'(l2); w = int'(w2); p = int'(p2); end
        endcase
    endtask

    function automatic int next_state(input int k, input int v);
        if (mmode[k] == 0)
            return ((v * 2) % 256) + ($countones(v & mtaps[k]) % 2);
        else
            return (v % 2 == 1) ? ((v / 2) ^ mtaps[k]) : (v / 2);
    endfunction

    task automatic model_cycle(input int k, input bit rst_low, input bit en, input bit ld,
                               input int sd, output int lk, output int wr);
        int nv;
        lk = 0;
        wr = 0;
        if (rst_low) begin
            mv[k] = 1; mstart[k] = 1; mcnt[k] = 0; mper[k] = 0;
        end else if (ld) begin
            if (sd != 0) mv[k] = sd;
            else begin mv[k] = 1; lk = 1; end
            mstart[k] = mv[k];
            mcnt[k]   = 0;
        end else if (en && mv[k] == 0) begin
            mv[k] = 1; lk = 1; mstart[k] = 1; mcnt[k] = 0;
        end else if (en) begin
            nv = next_state(k, mv[k]);
            if (nv == mstart[k]) begin
                wr = 1;
                mper[k] = (mcnt[k] + 1 > 255) ? 255 : mcnt[k] + 1;
                mcnt[k] = 0;
            end else begin
                mcnt[k] = (mcnt[k] + 1 > 255) ? 255 : mcnt[k] + 1;
            end
            mv[k] = nv;
        end
    endtask

    task automatic drive(input bit rst_low, input bit en, input bit ld, input int sd);
        int lk, wr, v, l, w, p;
        bit was_high;
        @(negedge clk);
        was_high = reset;
        reset   = !rst_low;
        enable  = en;
        load    = ld;
        seed_in = sd[7:0];
        for (int k = 0; k < 3; k++) begin
            model_cycle(k, rst_low, en, ld, sd, lk, wr);
            q.push_back(mv[k]);
            q.push_back(lk);
`ifdef LFSR_PERIOD_EN
            q.push_back(wr);
            q.push_back(mper[k]);
`else
            q.push_back(0);
            q.push_back(0);
`endif
        end
        if (rst_low && was_high) begin
            #1;
            for (int k = 0; k < 3; k++) begin
                sample(k, v, l, w, p);
                chk($sformatf("async_reset_value%0d", k), v, 1);
                chk($sformatf("async_reset_lockup%0d", k), l, 0);
            end
        end
    endtask

    initial begin : monitor
        int v, l, w, p;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() >= 12) begin
                for (int k = 0; k < 3; k++) begin
                    sample(k, v, l, w, p);
                    chk($sformatf("value%0d", k),  v, q.pop_front());
                    chk($sformatf("lockup%0d", k), l, q.pop_front());
                    chk($sformatf("wrap%0d", k),   w, q.pop_front());
                    chk($sformatf("period%0d", k), p, q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        int r, sd;
        reset   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        seed_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            mv[k] = 1; mstart[k] = 1; mcnt[k] = 0; mper[k] = 0;
        end

        repeat (4) drive(1'b1, 1'b0, 1'b0, 0);
        // Full maximal-length run from the seed back to the seed.
        repeat (255) drive(1'b0, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("fib_full_cycle_value", int'(v0), 'h01);
`ifdef LFSR_PERIOD_EN
        chk("fib_full_cycle_wrap", int'(w0), 1);
        chk("fib_full_cycle_period", int'(p0), 255);
`else
        chk("fib_wrap_tied", int'(w0), 0);
        chk("fib_period_tied", int'(p0), 0);
`endif

        drive(1'b0, 1'b1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b1, 'h5A);
        repeat (5) drive(1'b0, 1'b1, 1'b0, 0);
        repeat (10) drive(1'b0, 1'b0, 1'b0, 0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 0);

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            drive(r < 1, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 6, sd);
        end
        drive(1'b0, 1'b0, 1'b1, $urandom_range(1, 255));
        repeat (600) drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(posedge clk);
            #3;
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
